// File: rtl/clocked_shift_pkg.sv
// clocked_shift_pkg: shared mode codes, FSM states and mode classification for the shift engine
package clocked_shift_pkg;

    // Codes 6 and 7 are left unnamed; every consumer treats them as HOLD.
    typedef enum logic [2:0] {
        M_HOLD = 3'd0,
        M_LOAD = 3'd1,
        M_SHL  = 3'd2,
        M_SHR  = 3'd3,
        M_ROL  = 3'd4,
        M_ROR  = 3'd5
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic is_shift(input logic [2:0] m);
        return m >= M_SHL && m <= M_ROR;
    endfunction

endpackage

// File: rtl/clocked_shift_engine_step.sv
// shift_step: one combinational shift/rotate step of the working value
//   mode    : operation code (non-shift codes pass y through, out_bit=0)
//   y       : current working value
//   ser_in  : fill bit for SHL/SHR
//   y_next  : value after one step
//   out_bit : bit leaving y on this step
module shift_step
    import clocked_shift_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] y,
    input  logic             ser_in,
    output logic [WIDTH-1:0] y_next,
    output logic             out_bit
);

    always_comb begin
        y_next  = mode == M_SHL ? {y[WIDTH-2:0], ser_in}
                : mode == M_SHR ? {ser_in, y[WIDTH-1:1]}
                : mode == M_ROL ? {y[WIDTH-2:0], y[WIDTH-1]}
                : mode == M_ROR ? {y[0], y[WIDTH-1:1]}
                : y;
        out_bit = (mode == M_SHL || mode == M_ROL) ? y[WIDTH-1]
                : (mode == M_SHR || mode == M_ROR) ? y[0]
                : 1'b0;
    end

endmodule

// File: rtl/clocked_shift_engine.sv
// clocked_shift_engine: multi-cycle shift/rotate/load engine, one bit per clock
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, sampled only while idle, together with mode/amount/load_data
//   ser_in    : fill bit, sampled on every shift edge
//   y         : registered working value
//   ser_out   : bit shifted/rotated out on the latest step
//   busy      : multi-step operation in progress
//   done      : one-cycle completion pulse
module clocked_shift_engine
    import clocked_shift_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'('hAAAA),
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] y,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state, state_next;
    logic [CNT_W-1:0] count, n_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] step_y;
    logic             step_bit;
    logic             accept, launch, finish;

    // accept: any start seen while idle; launch: the subset that needs RUN
    assign accept = state == S_IDLE && start;
    assign launch = accept && is_shift(mode) && amount != '0;
    assign finish = state == S_RUN && count == CNT_W'(1);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode    (mode_q),
        .y       (y),
        .ser_in  (ser_in),
        .y_next  (step_y),
        .out_bit (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state == S_IDLE ? (launch ? S_RUN : S_IDLE)
                                     : (finish ? S_IDLE : S_RUN);
    end

    always_comb begin
        busy = state == S_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= RESET_VAL;
            ser_out <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            n_q     <= '0;
            mode_q  <= M_HOLD;
        end else begin
            done <= (accept && !launch) || finish;
            if (launch) begin
                count  <= amount;
                n_q    <= amount;
                mode_q <= mode;
            end else if (state == S_RUN) begin
                count <= count - CNT_W'(1);
            end
            if (accept && mode == M_LOAD) begin
                y <= load_data;
            end else if (state == S_RUN) begin
                y       <= step_y;
                ser_out <= step_bit;
            end
        end
    end

    // Properties below only mean something once a reset has completed.
    logic past_valid;

    always_ff @(posedge clk) begin
        past_valid <= !rst;
    end

    a_done_not_busy: assert property (@(posedge clk) disable iff (rst || !past_valid)
        !(done && busy));

    a_run_latch_stable: assert property (@(posedge clk) disable iff (rst || !past_valid)
        (busy && $past(busy)) |-> (mode_q == $past(mode_q) && n_q == $past(n_q)));

    a_count_bounded: assert property (@(posedge clk) disable iff (rst || !past_valid)
        count <= n_q);

endmodule

// File: tb/tb_clocked_shift_engine.sv
// tb_clocked_shift_engine: randomized and directed checks of clocked_shift_engine against a reference model
module tb_clocked_shift_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [6:0]  amount = '0;
    logic [63:0] load_data = '0;
    logic        ser_in = 1'b0;
    logic [63:0] y;
    logic        ser_out, busy, done;

    logic        start8 = 1'b0;
    logic [2:0]  mode8 = 3'd0;
    logic [3:0]  amount8 = '0;
    logic [7:0]  y8;
    logic        ser_out8, busy8, done8;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_y;
    logic        exp_so;

    always #5 clk = ~clk;

    clocked_shift_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
        .load_data(load_data), .ser_in(ser_in), .y(y), .ser_out(ser_out),
        .busy(busy), .done(done)
    );

    clocked_shift_engine #(.WIDTH(8), .RESET_VAL(8'h01)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .amount(amount8),
        .load_data(8'h00), .ser_in(1'b0), .y(y8), .ser_out(ser_out8),
        .busy(busy8), .done(done8)
    );

    // Whole-operation model: result of N steps computed in one go, fill bit held constant.
    task automatic model_apply(input logic [2:0] m, input int n, input logic [63:0] d, input logic f);
        int k;
        logic [63:0] fillmask;
        if (m == 3'd1) exp_y = d;
        else if (n > 0 && m == 3'd2) begin
            exp_so   = n <= 64 ? exp_y[64-n] : f;
            fillmask = n >= 64 ? '1 : (64'd1 << n) - 64'd1;
            exp_y    = n >= 64 ? {64{f}} : (exp_y << n) | (f ? fillmask : 64'd0);
        end else if (n > 0 && m == 3'd3) begin
            exp_so   = n <= 64 ? exp_y[n-1] : f;
            fillmask = n >= 64 ? '1 : ~(~64'd0 >> n);
            exp_y    = n >= 64 ? {64{f}} : (exp_y >> n) | (f ? fillmask : 64'd0);
        end else if (n > 0 && m == 3'd4) begin
            k      = n % 64;
            exp_y  = k == 0 ? exp_y : (exp_y << k) | (exp_y >> (64 - k));
            exp_so = exp_y[0];
        end else if (n > 0 && m == 3'd5) begin
            k      = n % 64;
            exp_y  = k == 0 ? exp_y : (exp_y >> k) | (exp_y << (64 - k));
            exp_so = exp_y[63];
        end
    endtask

    task automatic do_op(input logic [2:0] m, input int n, input logic [63:0] d, input logic f,
                         input bit glitch, input string tag);
        int busy_cnt = 0;
        int cyc = 0;
        int want_busy;
        @(negedge clk);
        start = 1'b1; mode = m; amount = 7'(n); load_data = d; ser_in = f;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 300) begin
            busy_cnt += int'(busy);
            if (glitch && busy) begin
                start     = 1'($urandom_range(0, 1));
                mode      = 3'($urandom);
                amount    = 7'($urandom);
                load_data = {$urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        model_apply(m, n, d, f);
        want_busy = (m >= 3'd2 && m <= 3'd5 && n > 0) ? n : 0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b want 1 (timeout)", tag, done); end
        checks++;
        if (busy_cnt != want_busy) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, want_busy); end
        checks++;
        if (y !== exp_y) begin errors++; $display("FAIL %s y: got %h want %h", tag, y, exp_y); end
        checks++;
        if (ser_out !== exp_so) begin errors++; $display("FAIL %s ser_out: got %b want %b", tag, ser_out, exp_so); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, done, busy); end
    endtask

    task automatic op8(input logic [2:0] m, input logic [3:0] n, input logic [7:0] want_y,
                       input logic want_so, input string tag);
        int cyc = 0;
        @(negedge clk);
        start8 = 1'b1; mode8 = m; amount8 = n;
        @(negedge clk);
        start8 = 1'b0;
        while (!done8 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done8 !== 1'b1) begin errors++; $display("FAIL %s done: got %b want 1 (timeout)", tag, done8); end
        checks++;
        if (y8 !== want_y) begin errors++; $display("FAIL %s y: got %h want %h", tag, y8, want_y); end
        checks++;
        if (ser_out8 !== want_so) begin errors++; $display("FAIL %s ser_out: got %b want %b", tag, ser_out8, want_so); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (y !== 64'h0000_0000_0000_AAAA || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            errors++;
            $display("FAIL reset64: got y=%h busy=%b done=%b so=%b want 000000000000aaaa 0 0 0", y, busy, done, ser_out);
        end
        checks++;
        if (y8 !== 8'h01 || busy8 !== 1'b0 || done8 !== 1'b0 || ser_out8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: got y=%h busy=%b done=%b so=%b want 01 0 0 0", y8, busy8, done8, ser_out8);
        end
        rst = 1'b0;
        exp_y = 64'hAAAA;
        exp_so = 1'b0;
    endtask

    task automatic test_rol4();
        do_op(3'd4, 4, 64'd0, 1'b0, 1'b0, "rol4");
        checks++;
        if (y !== 64'h0000_0000_000A_AAA0) begin errors++; $display("FAIL rol4_const: got %h want 00000000000aaaa0", y); end
    endtask

    task automatic test_reset_mid_run();
        int saw = 0;
        @(negedge clk);
        start = 1'b1; mode = 3'd3; amount = 7'd5; ser_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (y !== 64'hAAAA || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got y=%h busy=%b done=%b so=%b want 000000000000aaaa 0 0 0", y, busy, done, ser_out);
        end
        repeat (6) begin
            @(negedge clk);
            saw += int'(done) + int'(busy);
        end
        checks++;
        if (saw != 0) begin errors++; $display("FAIL midrst_quiet: got %0d done/busy cycles want 0", saw); end
        exp_y = 64'hAAAA;
        exp_so = 1'b0;
    endtask

    task automatic test_load_shl();
        do_op(3'd1, 0, 64'd0, 1'b0, 1'b0, "load0");
        do_op(3'd2, 3, 64'hFFFF, 1'b1, 1'b1, "shl3_glitch");
        checks++;
        if (y !== 64'h7) begin errors++; $display("FAIL shl3_const: got %h want 7", y); end
    endtask

    task automatic test_zero_and_hold();
        do_op(3'd1, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, "load_pattern");
        do_op(3'd2, 0, 64'hDEAD, 1'b1, 1'b0, "shl_amount0");
        do_op(3'd7, 9, 64'hBEEF, 1'b1, 1'b0, "mode7");
        do_op(3'd6, 3, 64'hBEEF, 1'b0, 1'b0, "mode6");
        do_op(3'd0, 5, 64'hBEEF, 1'b0, 1'b0, "hold");
        checks++;
        if (y !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL hold_const: got %h want 0123456789abcdef", y); end
    endtask

    task automatic test_width8();
        op8(3'd5, 4'd1, 8'h80, 1'b1, "w8_ror1");
        op8(3'd5, 4'd9, 8'h40, 1'b0, "w8_ror9");
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int cnt = 0;
        @(negedge clk);
        start = 1'b1; mode = 3'd2; amount = 7'd2; ser_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b1; mode = 3'd5; amount = 7'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 50) begin
            cnt += int'(busy);
            @(negedge clk);
            cyc++;
        end
        model_apply(3'd2, 2, 64'd0, 1'b0);
        model_apply(3'd5, 3, 64'd0, 1'b0);
        checks++;
        if (cnt != 3 || done !== 1'b1) begin errors++; $display("FAIL b2b_busy: got busy=%0d done=%b want 3 1", cnt, done); end
        checks++;
        if (y !== exp_y || ser_out !== exp_so) begin
            errors++;
            $display("FAIL b2b_value: got y=%h so=%b want %h %b", y, ser_out, exp_y, exp_so);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] m = 3'($urandom_range(0, 7));
            int n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 10));
            do_op(m, n, {$urandom, $urandom}, 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_rol4();
        test_reset_mid_run();
        test_load_shl();
        test_zero_and_hold();
        test_width8();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
